// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore FSM that sequences fetch and R-type ALU execute strobes.
// Define INSTR_COUNT_EN to add the instr_count retired-instruction counter output.
module control_sequencer #(
  parameter int REG_SEL_W   = 4,
  parameter int NUM_REGS    = 16,
  parameter int OPC_W       = 5,
  parameter int NUM_ALU_OPS = 16,
  parameter int HALT_OPC    = 27
) (
  input  logic                Clock,
  input  logic                clear,
  input  logic                run,
  input  logic                mem_ready,
  input  logic [31:0]         IR,
  output logic                PCout,
  output logic                Zlowout,
  output logic                MDRout,
  output logic                MARin,
  output logic                Zin,
  output logic                PCin,
  output logic                MDRin,
  output logic                IRin,
  output logic                Yin,
  output logic                IncPC,
  output logic                Read,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [OPC_W-1:0]    alu_op,
  output logic                busy,
  output logic                halted,
  output logic                illegal
`ifdef INSTR_COUNT_EN
  ,
  output logic [31:0]         instr_count
`endif
);

  localparam int OPC_LSB = 32 - OPC_W;
  localparam int RA_LSB  = OPC_LSB - REG_SEL_W;
  localparam int RB_LSB  = RA_LSB - REG_SEL_W;
  localparam int RC_LSB  = RB_LSB - REG_SEL_W;

  localparam logic [OPC_W:0]   ALU_LIMIT = NUM_ALU_OPS[OPC_W:0];
  localparam logic [OPC_W-1:0] HALT_CODE = HALT_OPC[OPC_W-1:0];

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T1W,
    S_T2,
    S_DEC,
    S_T3,
    S_T4,
    S_T5,
    S_HALT
  } state_t;

  state_t state_q, state_d;
  logic   run_prev_q, run_prev_d;

  logic [OPC_W-1:0]     opcode;
  logic [REG_SEL_W-1:0] ra_sel;
  logic [REG_SEL_W-1:0] rb_sel;
  logic [REG_SEL_W-1:0] rc_sel;
  logic                 is_alu;
  logic                 is_halt;
  logic                 run_rise;
  logic                 unused_ir_bits;

  assign opcode         = IR[31 -: OPC_W];
  assign ra_sel         = IR[RA_LSB +: REG_SEL_W];
  assign rb_sel         = IR[RB_LSB +: REG_SEL_W];
  assign rc_sel         = IR[RC_LSB +: REG_SEL_W];
  assign unused_ir_bits = ^IR[RC_LSB-1:0];

  assign is_alu   = ({1'b0, opcode} < ALU_LIMIT);
  assign is_halt  = (opcode == HALT_CODE);
  // HALT may only be left on a fresh 0->1 of run, so a run held high from before is ignored
  assign run_rise = run & ~run_prev_q;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_SEL_W-1:0] sel);
    onehot      = '0;
    onehot[sel] = 1'b1;
  endfunction

  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      state_q    <= S_IDLE;
      run_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_prev_q <= run_prev_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    run_prev_d = run;
    PCout      = 1'b0;
    Zlowout    = 1'b0;
    MDRout     = 1'b0;
    MARin      = 1'b0;
    Zin        = 1'b0;
    PCin       = 1'b0;
    MDRin      = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    IncPC      = 1'b0;
    Read       = 1'b0;
    reg_out    = '0;
    reg_in     = '0;
    alu_op     = '0;
    busy       = 1'b1;
    halted     = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (run) state_d = S_T0;
      end
      S_T0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        Zin     = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        state_d = mem_ready ? S_T2 : S_T1W;
      end
      // Wait state keeps the read going but must not reload PC a second time
      S_T1W: begin
        Read  = 1'b1;
        MDRin = 1'b1;
        if (mem_ready) state_d = S_T2;
      end
      S_T2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = S_DEC;
      end
      S_DEC: begin
        if (is_alu) begin
          state_d = S_T3;
        end else if (is_halt) begin
          state_d = S_HALT;
        end else begin
          illegal = 1'b1;
          state_d = S_T0;
        end
      end
      S_T3: begin
        reg_out = onehot(rb_sel);
        Yin     = 1'b1;
        state_d = S_T4;
      end
      S_T4: begin
        reg_out = onehot(rc_sel);
        alu_op  = opcode;
        Zin     = 1'b1;
        state_d = S_T5;
      end
      S_T5: begin
        Zlowout = 1'b1;
        reg_in  = onehot(ra_sel);
        state_d = run ? S_T0 : S_IDLE;
      end
      S_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
        if (run_rise) state_d = S_T0;
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef INSTR_COUNT_EN
  logic [31:0] count_q, count_d;

  // Every T5 exits to T0 or IDLE, so leaving T5 is exactly one retired ALU instruction
  always_comb begin
    count_d = count_q;
    if (state_q == S_T5) count_d = count_q + 32'd1;
  end

  always_ff @(posedge Clock or posedge clear) begin
    if (clear) count_q <= 32'd0;
    else       count_q <= count_d;
  end

  assign instr_count = count_q;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: drives scripted and random instructions and checks every cycle
// against an instruction-level expectation built from the sequencer's control rules.
module tb_control_sequencer;

   typedef struct packed {
      logic        PCout;
      logic        Zlowout;
      logic        MDRout;
      logic        MARin;
      logic        Zin;
      logic        PCin;
      logic        MDRin;
      logic        IRin;
      logic        Yin;
      logic        IncPC;
      logic        Read;
      logic [15:0] reg_out;
      logic [15:0] reg_in;
      logic [4:0]  alu_op;
      logic        busy;
      logic        halted;
      logic        illegal;
      logic [31:0] count;
   } vec_t;

   logic        Clock = 1'b0;
   logic        clear;
   logic        run;
   logic        mem_ready;
   logic [31:0] IR;
   logic        PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read;
   logic [15:0] reg_out;
   logic [15:0] reg_in;
   logic [4:0]  alu_op;
   logic        busy, halted, illegal;
`ifdef INSTR_COUNT_EN
   logic [31:0] instrCount;
`endif

   vec_t        actVec;
   vec_t        expVec;
   logic        expValid;
   string       expPhase;
   int          checks;
   int          errors;
   int          busyTotal;
   logic [31:0] modelCount;
   logic        endedIdle;
   vec_t        snapT1W, snapT3, snapT4, snapT5, snapDec, snapHalt;

   control_sequencer dut (
      .Clock      (Clock),
      .clear      (clear),
      .run        (run),
      .mem_ready  (mem_ready),
      .IR         (IR),
      .PCout      (PCout),
      .Zlowout    (Zlowout),
      .MDRout     (MDRout),
      .MARin      (MARin),
      .Zin        (Zin),
      .PCin       (PCin),
      .MDRin      (MDRin),
      .IRin       (IRin),
      .Yin        (Yin),
      .IncPC      (IncPC),
      .Read       (Read),
      .reg_out    (reg_out),
      .reg_in     (reg_in),
      .alu_op     (alu_op),
      .busy       (busy),
      .halted     (halted),
      .illegal    (illegal)
`ifdef INSTR_COUNT_EN
      ,
      .instr_count(instrCount)
`endif
   );

   // Free-running 10 ns clock
   always #5 Clock = ~Clock;

   // Gather every DUT output into one vector so a cycle is compared in one go
   always_comb begin
      actVec         = '0;
      actVec.PCout   = PCout;
      actVec.Zlowout = Zlowout;
      actVec.MDRout  = MDRout;
      actVec.MARin   = MARin;
      actVec.Zin     = Zin;
      actVec.PCin    = PCin;
      actVec.MDRin   = MDRin;
      actVec.IRin    = IRin;
      actVec.Yin     = Yin;
      actVec.IncPC   = IncPC;
      actVec.Read    = Read;
      actVec.reg_out = reg_out;
      actVec.reg_in  = reg_in;
      actVec.alu_op  = alu_op;
      actVec.busy    = busy;
      actVec.halted  = halted;
      actVec.illegal = illegal;
`ifdef INSTR_COUNT_EN
      actVec.count   = instrCount;
`endif
   end

   // Give up on a hung run but still leave a visible failure line
   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "[TB] watchdog");
   end

   // Every vector starts from all-strobes-off plus the retired count the model holds
   function automatic vec_t baseVec();
      vec_t v;
      v = '0;
`ifdef INSTR_COUNT_EN
      v.count = modelCount;
`endif
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s t=%0t got %h want %h", name, $time, act, exp);
      end
   endtask

   // Compares the DUT against the current expectation at every falling edge
   task automatic compareLoop();
      forever begin
         @(negedge Clock);
         if (actVec.busy) busyTotal++;
         if (expValid) checkOutput(expPhase, 128'(actVec), 128'(expVec));
      end
   endtask

   // One clock cycle: set inputs and expectation just after the rising edge
   task automatic applyStimulus(input string phase, input logic r, input logic mr,
                                input vec_t e, output vec_t snap);
      run       = r;
      mem_ready = mr;
      expVec    = e;
      expPhase  = phase;
      expValid  = 1'b1;
      @(negedge Clock);
      snap = actVec;
      @(posedge Clock);
      #1;
   endtask

   // Idle with run low for n cycles, then raise run so the next cycle is T0
   task automatic idleThenGo(input int n);
      vec_t e, s;
      e = baseVec();
      for (int i = 0; i < n; i++) applyStimulus("IDLE", 1'b0, 1'($urandom_range(0, 1)), e, s);
      applyStimulus("IDLEgo", 1'b1, 1'($urandom_range(0, 1)), e, s);
   endtask

   // One instruction from its T0 cycle onward, with the expected strobes of each step
   task automatic runInstr(input logic [31:0] ir, input int waits, input logic endRun,
                           input int haltHold, input logic abortT4);
      vec_t       e, s;
      logic [4:0] op;
      logic [3:0] ra, rb, rc;
      op = ir[31:27];
      ra = ir[26:23];
      rb = ir[22:19];
      rc = ir[18:15];
      IR = ir;
      endedIdle = 1'b0;

      e = baseVec(); e.busy = 1'b1; e.PCout = 1'b1; e.MARin = 1'b1; e.IncPC = 1'b1; e.Zin = 1'b1;
      applyStimulus("T0", 1'b1, 1'($urandom_range(0, 1)), e, s);

      e = baseVec(); e.busy = 1'b1; e.Zlowout = 1'b1; e.PCin = 1'b1; e.Read = 1'b1; e.MDRin = 1'b1;
      applyStimulus("T1", 1'b1, (waits == 0), e, s);

      for (int k = 1; k <= waits; k++) begin
         e = baseVec(); e.busy = 1'b1; e.Read = 1'b1; e.MDRin = 1'b1;
         applyStimulus("T1W", 1'b1, (k == waits), e, s);
         snapT1W = s;
      end

      e = baseVec(); e.busy = 1'b1; e.MDRout = 1'b1; e.IRin = 1'b1;
      applyStimulus("T2", 1'b1, 1'($urandom_range(0, 1)), e, s);

      e = baseVec(); e.busy = 1'b1; e.illegal = (op >= 5'd16) && (op != 5'd27);
      applyStimulus("DEC", 1'b1, 1'($urandom_range(0, 1)), e, s);
      snapDec = s;

      if (op == 5'd27) begin
         e = baseVec(); e.halted = 1'b1;
         for (int i = 0; i < haltHold; i++) begin
            applyStimulus("HALThold", 1'b1, 1'($urandom_range(0, 1)), e, s);
            if (i == 0) snapHalt = s;
         end
         applyStimulus("HALTlow", 1'b0, 1'($urandom_range(0, 1)), e, s);
         if (haltHold == 0) snapHalt = s;
         applyStimulus("HALTrise", 1'b1, 1'($urandom_range(0, 1)), e, s);
         return;
      end
      if (op >= 5'd16) return;

      e = baseVec(); e.busy = 1'b1; e.reg_out = 16'(1) << rb; e.Yin = 1'b1;
      applyStimulus("T3", 1'b1, 1'($urandom_range(0, 1)), e, s);
      snapT3 = s;

      e = baseVec(); e.busy = 1'b1; e.reg_out = 16'(1) << rc; e.alu_op = op; e.Zin = 1'b1;
      if (abortT4) begin
         run       = 1'b1;
         mem_ready = 1'b0;
         expVec    = e;
         expPhase  = "T4";
         expValid  = 1'b1;
         #2;
         modelCount = '0;
         expVec     = baseVec();
         expPhase   = "clearedT4";
         clear      = 1'b1;
         #1;
         checkOutput("clearMidT4", 128'(actVec), 128'(0));
         @(posedge Clock);
         #1;
         clear     = 1'b0;
         run       = 1'b0;
         endedIdle = 1'b1;
         return;
      end
      applyStimulus("T4", 1'b1, 1'($urandom_range(0, 1)), e, s);
      snapT4 = s;

      e = baseVec(); e.busy = 1'b1; e.Zlowout = 1'b1; e.reg_in = 16'(1) << ra;
      applyStimulus("T5", endRun, 1'($urandom_range(0, 1)), e, s);
      snapT5 = s;
      modelCount = modelCount + 32'd1;
      endedIdle  = !endRun;
   endtask

   initial begin
      int          b0;
      logic [4:0]  op;
      logic [31:0] rnd;
      logic [31:0] ir;
      checks     = 0;
      errors     = 0;
      busyTotal  = 0;
      modelCount = '0;
      expValid   = 1'b0;
      expPhase   = "none";
      clear      = 1'b1;
      run        = 1'b0;
      mem_ready  = 1'b0;
      IR         = '0;
      fork
         compareLoop();
      join_none

      repeat (2) @(posedge Clock);
      #1;
      checkOutput("resetState", 128'(actVec), 128'(0));
      clear = 1'b0;
      idleThenGo(2);

      // Reference instruction: opcode 5, Ra=1, Rb=2, Rc=3, memory always ready
      b0 = busyTotal;
      runInstr(32'h28918000, 0, 1'b0, 0, 1'b0);
      checkOutput("latency7", 128'(busyTotal - b0), 128'(7));
      checkOutput("T3regOut", 128'(snapT3.reg_out), 128'(16'h0004));
      checkOutput("T3Yin", 128'(snapT3.Yin), 128'(1));
      checkOutput("T4regOut", 128'(snapT4.reg_out), 128'(16'h0008));
      checkOutput("T4aluOp", 128'(snapT4.alu_op), 128'(5));
      checkOutput("T4Zin", 128'(snapT4.Zin), 128'(1));
      checkOutput("T5regIn", 128'(snapT5.reg_in), 128'(16'h0002));
      checkOutput("T5Zlowout", 128'(snapT5.Zlowout), 128'(1));

      idleThenGo(1);
      b0 = busyTotal;
      runInstr(32'h28918000, 3, 1'b0, 0, 1'b0);
      checkOutput("latency10", 128'(busyTotal - b0), 128'(10));
      checkOutput("T1Wstrobes", 128'({snapT1W.Read, snapT1W.MDRin, snapT1W.PCin}), 128'(3'b110));

      idleThenGo(1);
      runInstr(32'hD8000000, 0, 1'b1, 2, 1'b0);
      checkOutput("haltHalted", 128'(snapHalt.halted), 128'(1));
      checkOutput("haltBusy", 128'(snapHalt.busy), 128'(0));

      runInstr(32'hA0000000, 1, 1'b1, 0, 1'b0);
      checkOutput("decIllegal", 128'(snapDec.illegal), 128'(1));
      checkOutput("decRegIn", 128'(snapDec.reg_in), 128'(0));

      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 9))
            0: begin
               op = 5'($urandom_range(16, 31));
               if (op == 5'd27) op = 5'd20;
            end
            1:       op = 5'd27;
            default: op = 5'($urandom_range(0, 15));
         endcase
         rnd = $urandom();
         ir  = {op, rnd[26:0]};
         runInstr(ir, $urandom_range(0, 3), ($urandom_range(0, 3) != 0), $urandom_range(0, 3), 1'b0);
         if (endedIdle) idleThenGo($urandom_range(1, 3));
      end

      // Abort mid-execute, then stay idle with run low before restarting
      runInstr(32'h28918000, 0, 1'b1, 0, 1'b1);
      idleThenGo(3);

      runInstr(32'h08918000, 0, 1'b1, 0, 1'b0);
      runInstr(32'h5A5A5A5A, 2, 1'b1, 0, 1'b0);
      runInstr(32'h7FFF8000, 1, 1'b1, 0, 1'b0);
      runInstr(32'hA0000000, 0, 1'b1, 0, 1'b0);
`ifdef INSTR_COUNT_EN
      checkOutput("instrCount3", 128'(instrCount), 128'(3));
`endif

      expValid = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
